// File: rtl/run_sequencer.sv
// Host-side run sequencer: loads operands into data memory, resets and starts the core,
// waits for done with a timeout, then streams result bytes back out of data memory.
module run_sequencer #(
   parameter int AW      = 8,
   parameter int LOAD_LO = 0,
   parameter int LOAD_N  = 64,
   parameter int RES_LO  = 64,
   parameter int RES_N   = 64,
   parameter int RST_CYC = 2,
   parameter int TIMEOUT = 4096,
   parameter int CW      = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          ld_valid,
   input  logic [7:0]    ld_data,
   output logic          ld_ready,
   output logic          res_valid,
   output logic [7:0]    res_data,
   input  logic          res_ready,
   output logic          mem_wr_en,
   output logic [AW-1:0] mem_addr,
   output logic [7:0]    mem_wr_data,
   input  logic [7:0]    mem_rd_data,
   output logic          dut_reset,
   output logic          dut_req,
   input  logic          dut_done,
   output logic          busy,
   output logic          finished,
   output logic          timed_out,
   output logic [CW-1:0] run_cycles
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_RST  = 3'd2,
      S_REQ  = 3'd3,
      S_RUN  = 3'd4,
      S_READ = 3'd5,
      S_DONE = 3'd6,
      S_ERR  = 3'd7
   } state_t;

   localparam int IW = 16;
   localparam logic [IW-1:0] LOAD_LAST = IW'(LOAD_N - 1);
   localparam logic [IW-1:0] RST_LAST  = IW'(RST_CYC - 1);
   localparam logic [IW-1:0] RES_LAST  = IW'(RES_N - 1);
   localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
   // A timeout beyond the counter range collapses onto the saturation value.
   localparam logic [CW-1:0] TMO_LIM   = (64'(TIMEOUT) >= 64'(CNT_MAX)) ? CNT_MAX : CW'(TIMEOUT);

   state_t        state_r, state_s;
   logic [IW-1:0] idx_r, idx_s;
   logic [CW-1:0] run_cycles_r, run_cycles_s, cyc_inc_s;
   logic [AW-1:0] load_addr_s, res_addr_s;

   assign cyc_inc_s   = (run_cycles_r == CNT_MAX) ? CNT_MAX : run_cycles_r + CW'(1);
   assign load_addr_s = AW'(LOAD_LO) + AW'(idx_r);
   assign res_addr_s  = AW'(RES_LO) + AW'(idx_r);

   // State, index and run-cycle registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= S_IDLE;
         idx_r        <= '0;
         run_cycles_r <= '0;
      end else begin
         state_r      <= state_s;
         idx_r        <= idx_s;
         run_cycles_r <= run_cycles_s;
      end
   end

   // Next-state, index and run-cycle update.
   always_comb begin
      state_s      = state_r;
      idx_s        = idx_r;
      run_cycles_s = run_cycles_r;
      case (state_r)
         S_IDLE, S_ERR: begin
            if (start) begin
               state_s      = (LOAD_N == 0) ? S_RST : S_LOAD;
               idx_s        = '0;
               run_cycles_s = '0;
            end else begin
               state_s = state_r;
            end
         end
         S_LOAD: begin
            if (ld_valid && (idx_r == LOAD_LAST)) begin
               state_s = S_RST;
               idx_s   = '0;
            end else if (ld_valid) begin
               idx_s = idx_r + IW'(1);
            end else begin
               idx_s = idx_r;
            end
         end
         S_RST: begin
            if ((RST_CYC <= 1) || (idx_r == RST_LAST)) begin
               state_s = S_REQ;
               idx_s   = '0;
            end else begin
               idx_s = idx_r + IW'(1);
            end
         end
         S_REQ: begin
            state_s      = S_RUN;
            run_cycles_s = '0;
         end
         // Done takes priority over timeout when both land on the same cycle.
         S_RUN: begin
            run_cycles_s = cyc_inc_s;
            if (dut_done) begin
               state_s = (RES_N == 0) ? S_DONE : S_READ;
            end else if (cyc_inc_s >= TMO_LIM) begin
               state_s = S_ERR;
            end else begin
               state_s = S_RUN;
            end
         end
         S_READ: begin
            if (res_ready && (idx_r == RES_LAST)) begin
               state_s = S_DONE;
               idx_s   = '0;
            end else if (res_ready) begin
               idx_s = idx_r + IW'(1);
            end else begin
               idx_s = idx_r;
            end
         end
         S_DONE:  state_s = S_IDLE;
         default: state_s = S_IDLE;
      endcase
   end

   // Output decode from the registered state.
   always_comb begin
      ld_ready    = (state_r == S_LOAD);
      mem_wr_en   = (state_r == S_LOAD) && ld_valid;
      mem_wr_data = (state_r == S_LOAD) ? ld_data : 8'h00;
      res_valid   = (state_r == S_READ);
      res_data    = (state_r == S_READ) ? mem_rd_data : 8'h00;
      dut_reset   = (state_r == S_RST);
      dut_req     = (state_r == S_REQ);
      busy        = (state_r != S_IDLE) && (state_r != S_ERR);
      finished    = (state_r == S_DONE);
      timed_out   = (state_r == S_ERR);
      run_cycles  = run_cycles_r;
      if (state_r == S_LOAD) begin
         mem_addr = load_addr_s;
      end else if (state_r == S_READ) begin
         mem_addr = res_addr_s;
      end else begin
         mem_addr = '0;
      end
   end

endmodule

// File: tb/tb_run_sequencer.sv
// Randomized scoreboard bench for run_sequencer: a wrapping-address instance with a
// behavioural memory/core model, plus a no-load/no-readback instance with done stuck high.
module tb_run_sequencer;

   localparam int AW = 8, LOAD_LO = 254, LOAD_N = 4, RES_LO = 255, RES_N = 3;
   localparam int RST_CYC = 2, TIMEOUT = 16, CW = 16;

   logic clk;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset, start, ld_valid, ld_ready, res_valid, res_ready;
   logic [7:0]    ld_data, res_data, mem_wr_data, mem_rd_data;
   logic          mem_wr_en, dut_reset, dut_req, dut_done, busy, finished, timed_out;
   logic [AW-1:0] mem_addr;
   logic [CW-1:0] run_cycles;

   logic          start_b, ld_ready_b, res_valid_b, mem_wr_en_b;
   logic [7:0]    res_data_b, mem_wr_data_b;
   logic [7:0]    mem_addr_b;
   logic          dut_reset_b, dut_req_b, busy_b, finished_b, timed_out_b;
   logic [15:0]   run_cycles_b;

   run_sequencer #(.AW(AW), .LOAD_LO(LOAD_LO), .LOAD_N(LOAD_N), .RES_LO(RES_LO), .RES_N(RES_N),
                   .RST_CYC(RST_CYC), .TIMEOUT(TIMEOUT), .CW(CW)) dut_a (
      .clk(clk), .reset(reset), .start(start), .ld_valid(ld_valid), .ld_data(ld_data),
      .ld_ready(ld_ready), .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
      .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
      .mem_rd_data(mem_rd_data), .dut_reset(dut_reset), .dut_req(dut_req), .dut_done(dut_done),
      .busy(busy), .finished(finished), .timed_out(timed_out), .run_cycles(run_cycles));

   run_sequencer #(.AW(8), .LOAD_LO(0), .LOAD_N(0), .RES_LO(64), .RES_N(0),
                   .RST_CYC(2), .TIMEOUT(16), .CW(16)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .ld_valid(1'b0), .ld_data(8'h00),
      .ld_ready(ld_ready_b), .res_valid(res_valid_b), .res_data(res_data_b), .res_ready(1'b0),
      .mem_wr_en(mem_wr_en_b), .mem_addr(mem_addr_b), .mem_wr_data(mem_wr_data_b),
      .mem_rd_data(8'h00), .dut_reset(dut_reset_b), .dut_req(dut_req_b), .dut_done(1'b1),
      .busy(busy_b), .finished(finished_b), .timed_out(timed_out_b), .run_cycles(run_cycles_b));

   // Data memory with combinational read.
   logic [7:0] mem [256];
   logic [7:0] ref_mem [256];
   assign mem_rd_data = mem[mem_addr];
   always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_wr_data;

   // Core model: done rises core_delay cycles after req is seen and stays high until the next req.
   int          core_delay;
   logic        armed;
   logic [15:0] run_ctr;
   always @(posedge clk) begin
      if (reset) begin
         armed   <= 1'b0;
         run_ctr <= 16'd0;
      end else if (dut_req) begin
         armed   <= 1'b1;
         run_ctr <= 16'd1;
      end else if (armed && run_ctr != 16'hFFFF) begin
         run_ctr <= run_ctr + 16'd1;
      end
   end
   assign dut_done = armed && (int'(run_ctr) >= core_delay);

   typedef struct packed { logic [1:0] kind; logic [15:0] a; logic [15:0] b; } evt_t;
   evt_t       exp_q[$];
   logic [5:0] qb[$];
   int checks = 0, failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic pop_cmp(input logic [1:0] kind, input logic [15:0] a, input logic [15:0] b);
      evt_t e;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL unexpected_event actual=kind%0d/%0h/%0h required=none", kind, a, b);
      end else begin
         e = exp_q.pop_front();
         check("evt_kind", 64'(kind), 64'(e.kind));
         check("evt_a", 64'(a), 64'(e.a));
         check("evt_b", 64'(b), 64'(e.b));
      end
   endtask

   // Monitor for instance A: writes, result handshakes, completion and timeout events.
   initial begin : mon_a
      logic       hold_v, tmo_prev;
      logic [7:0] hold_d;
      int         rst_cnt, req_cnt;
      hold_v = 1'b0; tmo_prev = 1'b0; hold_d = 8'h00; rst_cnt = 0; req_cnt = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            hold_v = 1'b0; tmo_prev = 1'b0; rst_cnt = 0; req_cnt = 0;
         end else begin
            if (mem_wr_en || res_valid) check("wr_rd_exclusive", 64'(mem_wr_en & res_valid), 64'd0);
            if (mem_wr_en) pop_cmp(2'd0, 16'(mem_addr), 16'(mem_wr_data));
            if (res_valid) begin
               if (hold_v) check("res_data_stable", 64'(res_data), 64'(hold_d));
               if (res_ready) begin
                  pop_cmp(2'd1, 16'(mem_addr), 16'(res_data));
                  hold_v = 1'b0;
               end else begin
                  hold_v = 1'b1;
                  hold_d = res_data;
               end
            end else begin
               hold_v = 1'b0;
            end
            if (dut_reset) rst_cnt++;
            if (dut_req) begin
               check("rst_cycles", 64'(rst_cnt), 64'(RST_CYC));
               rst_cnt = 0;
               req_cnt++;
            end
            if (finished) begin
               pop_cmp(2'd2, run_cycles, 16'(busy));
               check("req_pulses", 64'(req_cnt), 64'd1);
               req_cnt = 0;
            end
            if (timed_out && !tmo_prev) begin
               pop_cmp(2'd3, run_cycles, 16'(busy));
               check("req_pulses_tmo", 64'(req_cnt), 64'd1);
               req_cnt = 0;
            end
            tmo_prev = timed_out;
         end
      end
   end

   // Monitor for instance B: per-cycle control sequence while busy.
   initial begin : mon_b
      forever begin
         @(negedge clk);
         if (!reset && busy_b) begin
            if (qb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL b_extra_busy_cycle actual=busy required=idle");
            end else begin
               check("b_sequence", 64'({dut_reset_b, dut_req_b, finished_b, ld_ready_b, res_valid_b, mem_wr_en_b}),
                     64'(qb.pop_front()));
            end
         end
      end
   end

   task automatic do_reset();
      reset = 1'b1; ld_valid = 1'b0; res_ready = 1'b0;
      @(posedge clk); #1;
      check("reset_outputs", 64'({ld_ready, res_valid, res_data, mem_wr_en, mem_addr, mem_wr_data,
                                  dut_reset, dut_req, busy, finished, timed_out, run_cycles}), 64'd0);
      exp_q.delete();
      reset = 1'b0;
   endtask

   // One run on instance A; abort_at 1 = reset mid-load, 2 = reset mid-readback.
   task automatic run_a(input int delay, input int abort_at, input int first_stall);
      logic [7:0]    d;
      logic [AW-1:0] addr;
      int            budget, stall;
      core_delay = delay;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_after_start", 64'(busy), 64'd1);
      check("timed_out_cleared", 64'(timed_out), 64'd0);
      check("run_cycles_cleared", 64'(run_cycles), 64'd0);
      for (int i = 0; i < LOAD_N; i++) begin
         while ($urandom_range(0, 2) == 0) begin
            ld_valid = 1'b0;
            @(posedge clk); #1;
         end
         check("ld_ready", 64'(ld_ready), 64'd1);
         d = 8'($urandom);
         addr = AW'(LOAD_LO + i);
         ld_valid = 1'b1; ld_data = d; ref_mem[addr] = d;
         exp_q.push_back('{kind: 2'd0, a: 16'(addr), b: 16'(d)});
         @(posedge clk); #1;
         if (abort_at == 1 && i == 1) begin
            do_reset();
            return;
         end
      end
      ld_valid = 1'b0;
      if (delay <= TIMEOUT) begin
         for (int j = 0; j < RES_N; j++) begin
            addr = AW'(RES_LO + j);
            exp_q.push_back('{kind: 2'd1, a: 16'(addr), b: 16'(ref_mem[addr])});
         end
         exp_q.push_back('{kind: 2'd2, a: 16'(delay), b: 16'd1});
         budget = 0;
         while (!res_valid && budget < 200) begin
            @(posedge clk); #1;
            budget++;
         end
         check("res_valid_wait", 64'(res_valid), 64'd1);
         for (int j = 0; j < RES_N; j++) begin
            if (abort_at == 2 && j == 1) begin
               do_reset();
               return;
            end
            stall = (j == 0) ? first_stall : $urandom_range(0, 3);
            repeat (stall) begin
               @(posedge clk); #1;
            end
            res_ready = 1'b1;
            @(posedge clk); #1;
            res_ready = 1'b0;
         end
      end else begin
         exp_q.push_back('{kind: 2'd3, a: 16'(TIMEOUT), b: 16'd0});
      end
      budget = 0;
      while (busy && budget < 200) begin
         @(posedge clk); #1;
         budget++;
      end
      check("busy_drop", 64'(busy), 64'd0);
      check("timed_out_level", 64'(timed_out), 64'(delay > TIMEOUT));
      @(posedge clk); #1;
      check("queue_drained", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      int budget;
      reset = 1'b1; start = 1'b0; ld_valid = 1'b0; ld_data = 8'h00; res_ready = 1'b0;
      start_b = 1'b0; core_delay = 10;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs_init", 64'({ld_ready, res_valid, res_data, mem_wr_en, mem_addr, mem_wr_data,
                                       dut_reset, dut_req, busy, finished, timed_out, run_cycles}), 64'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      run_a(10, 0, 3);
      run_a(1, 0, 0);
      run_a(16, 0, 1);
      run_a(20, 0, 0);
      run_a(5, 0, 2);
      run_a(8, 1, 0);
      run_a(8, 2, 0);
      run_a(7, 0, 0);
      for (int k = 0; k < 6; k++) run_a($urandom_range(1, 24), 0, $urandom_range(0, 3));

      qb.push_back(6'b100000);
      qb.push_back(6'b100000);
      qb.push_back(6'b010000);
      qb.push_back(6'b000000);
      qb.push_back(6'b001000);
      start_b = 1'b1;
      @(posedge clk); #1;
      start_b = 1'b0;
      budget = 0;
      while (busy_b && budget < 50) begin
         @(posedge clk); #1;
         budget++;
      end
      check("b_busy_drop", 64'(busy_b), 64'd0);
      @(posedge clk); #1;
      check("b_queue_drained", 64'(qb.size()), 64'd0);
      check("b_run_cycles", 64'(run_cycles_b), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
